mdu_div: RTL

Iterative radix-2 restoring divider for the execute-stage multiply/divide path, directly upstream of the HI/LO register pair. It accepts DIV/DIVU operands, runs 32 subtract-shift iterations, and presents remainder (HI) and quotient (LO) with a `complete` level that the HI/LO write logic qualifies with pipeline `ready`. It is cancellable by exception flush at any cycle.

---
 rtl/mdu_pkg.sv | 16 +
 rtl/mdu_div_step.sv | 36 +++
 rtl/mdu_div.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   div_state_t  : divider sequencer states
//   DIV_ITER     : restoring iterations for a 32-bit divide
//   DIV_ZERO_QUO : quotient returned for a divide by zero
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int unsigned DIV_ITER     = 32;
    localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_div_step.sv
// div_step: one combinational radix-2 restoring division step.
// Shifts {rem, quo} left by one. If the shifted remainder is at least the
// divisor, it subtracts the divisor and sets the new quotient LSB.
//   rem_in/rem_out : partial remainder, WIDTH+1 bits
//   quo_in/quo_out : partial quotient / remaining dividend bits
//   divisor        : divisor magnitude
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        // A set rem_in MSB would shift out of 'shifted'. In that case the true
        // value exceeds any divisor, so the step must subtract.
        ge      = rem_in[WIDTH] || (shifted >= {1'b0, divisor});
        if (ge) begin
            rem_out = diff;
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = shifted;
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_div.sv
// mdu_div: iterative radix-2 restoring divider (DIV/DIVU) feeding HI/LO.
//   clk, resetn             : clock, asynchronous active-low reset
//   div_start, div_signed   : request and signedness, sampled on acceptance
//   dividend, divisor       : operands, sampled on acceptance
//   ready                   : consumer acknowledge while complete is high
//   exception_flush         : cancels any operation; flush wins over a start
//   busy                    : high while iterating (CALC)
//   complete                : high in DONE; hi_val/lo_val are valid
//   hi_val, lo_val          : remainder and quotient (registered)
// Optional feature macro: MDU_DIV_ZERO_FAST_EN. When it is defined, a zero
// divisor bypasses CALC and reaches DONE one edge after acceptance.
module mdu_div
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             ready,
    input  logic             exception_flush,
    output logic             busy,
    output logic             complete,
    output logic [WIDTH-1:0] hi_val,
    output logic [WIDTH-1:0] lo_val
);

`ifdef MDU_DIV_ZERO_FAST_EN
    localparam bit ZERO_FAST = 1'b1;
`else
    localparam bit ZERO_FAST = 1'b0;
`endif

    localparam int unsigned CW = $clog2(WIDTH + 1);

    div_state_t       state, state_nxt;
    logic [CW-1:0]    counter;
    logic [WIDTH:0]   rem, rem_step;
    logic [WIDTH-1:0] quo, quo_step;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dividend_raw;
    logic             q_neg, r_neg, dz;
    logic             zero_pend;
    logic             accept, finish, load_zero, dz_now;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dvs_mag),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        load_zero = 1'b0;
        dz_now    = (divisor == '0);
        unique case (state)
            IDLE: begin
                // A fast zero-divide waits here for one cycle, then loads its result.
                if (zero_pend) begin
                    load_zero = 1'b1;
                    state_nxt = DONE;
                end else if (div_start) begin
                    accept    = 1'b1;
                    state_nxt = (ZERO_FAST && dz_now) ? IDLE : CALC;
                end
            end
            CALC: begin
                if (counter == CW'(WIDTH)) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (ready) begin
                    if (div_start) begin
                        accept    = 1'b1;
                        state_nxt = (ZERO_FAST && dz_now) ? IDLE : CALC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (exception_flush) begin
            state_nxt = IDLE;
            accept    = 1'b0;
            finish    = 1'b0;
            load_zero = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            counter      <= '0;
            rem          <= '0;
            quo          <= '0;
            dvs_mag      <= '0;
            dividend_raw <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            dz           <= 1'b0;
            zero_pend    <= 1'b0;
            hi_val       <= '0;
            lo_val       <= '0;
        end else begin
            zero_pend <= accept && ZERO_FAST && dz_now;
            if (accept) begin
                rem          <= '0;
                quo          <= magnitude(dividend, div_signed);
                dvs_mag      <= magnitude(divisor, div_signed);
                dividend_raw <= dividend;
                q_neg        <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_neg        <= div_signed && dividend[WIDTH-1];
                dz           <= dz_now;
                counter      <= '0;
            end else if (state == CALC && !finish) begin
                rem     <= rem_step;
                quo     <= quo_step;
                counter <= counter + CW'(1);
            end
            if (finish) begin
                if (dz) begin
                    hi_val <= dividend_raw;
                    lo_val <= '1;
                end else begin
                    hi_val <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    lo_val <= q_neg ? -quo : quo;
                end
            end
            if (load_zero) begin
                hi_val <= dividend_raw;
                lo_val <= '1;
            end
        end
    end

    always_comb begin
        busy     = (state == CALC);
        complete = (state == DONE);
    end

endmodule
